// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : issue/write-back controller feeding a registered 8-bit ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 6,
  parameter int NREGS  = 4,
  parameter int RA_W   = 2,
  parameter int MAX_OP = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [23:0]       instr,
  output logic [OP_W-1:0]   alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              done,
  output logic              illegal,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] MAX_OP_C = OP_W'(MAX_OP);

  state_t              state_q, state_d;
  logic [RA_W-1:0]     rd_q;
  logic [WORD_W-1:0]   rf_q [NREGS];
  logic [OP_W-1:0]     alu_op_q;
  logic [WORD_W-1:0]   alu_a_q, alu_b_q;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                issue_en, wb_en;

  logic [OP_W-1:0]     op_w;
  logic [RA_W-1:0]     rd_w, rs1_w, rs2_w;
  logic                use_imm_w;
  logic [WORD_W-1:0]   imm_w;
  logic                unused_rsvd;

  assign op_w        = instr[23:18];
  assign rd_w        = instr[17:16];
  assign rs1_w       = instr[15:14];
  assign rs2_w       = instr[13:12];
  assign use_imm_w   = instr[11];
  assign imm_w       = instr[7:0];
  assign unused_rsvd = ^instr[10:8];

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    issue_en  = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (op_w <= MAX_OP_C) begin
            state_d  = ISSUE;
            issue_en = 1'b1;
          end else begin
            // Illegal ops retire straight from IDLE without touching the ALU.
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WB;
      WB: begin
        state_d = IDLE;
        wb_en   = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (issue_en) begin
        rd_q     <= rd_w;
        alu_op_q <= op_w;
        alu_a_q  <= rf_q[rs1_w];
        alu_b_q  <= use_imm_w ? imm_w : rf_q[rs2_w];
      end
      if (wb_en) begin
        rf_q[rd_q] <= alu_result;
        flags_q    <= alu_flags;
      end
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction-issue and write-back controller that sits directly upstream of the 8-bit ALU.
- Owns a small register file and accepts one decoded instruction word via valid/ready.
- Drives the ALU operands and op_code, waits one cycle for the ALU's registered result, then writes the result back to the register file.
- Latches the ALU's NZCV flags into an architectural status register.

Parameters:
WORD_W, 8, datapath width; must match the ALU.
OP_W, 6, opcode width; must match the ALU.
NREGS, 4, number of registers in the file.
RA_W, 2, register address width; equals log2(NREGS).
MAX_OP, 10, highest legal opcode (PASSB); larger codes are illegal.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  instruction word present.
instr_ready  out  1  controller can accept; combinational, equals (state==IDLE).
instr  in  24  fields: [23:18] op, [17:16] rd, [15:14] rs1, [13:12] rs2, [11] use_imm, [10:8] reserved (ignored), [7:0] imm.
alu_op  out  OP_W  to ALU op_code.
alu_a  out  WORD_W  to ALU d_in0.
alu_b  out  WORD_W  to ALU d_in1.
alu_result  in  WORD_W  from ALU d_out; registered in the ALU.
alu_flags  in  4  from ALU flags; bit 3 N, bit 2 Z, bit 1 C, bit 0 V.
flags_q  out  4  architectural NZCV status register.
done  out  1  one-cycle pulse after a write-back or illegal retire.
illegal  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
dbg_addr  in  RA_W  debug read address.
dbg_data  out  WORD_W  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, any state):
  - state = IDLE; all rf entries = 0; flags_q = 0.
  - alu_op = 0, alu_a = 0, alu_b = 0; done = 0; illegal = 0.
  - Any in-flight instruction is discarded and no write-back occurs.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch instr into an internal register.
  - If op <= MAX_OP, go to ISSUE.
  - Otherwise stay in IDLE and, in the next cycle, pulse done and illegal. No ALU drive, rf and flags_q unchanged.
- ISSUE (1 cycle):
  - alu_op, alu_a and alu_b are registered outputs.
  - They are loaded at the IDLE→ISSUE edge: alu_op = op, alu_a = rf[rs1], alu_b = use_imm ? imm : rf[rs2].
  - They are valid throughout ISSUE. The ALU captures them at the ISSUE→WB edge.
- WB (1 cycle):
  - alu_result and alu_flags reflect the issued instruction.
  - At the WB→IDLE edge: rf[rd] <= alu_result, flags_q <= alu_flags, done <= 1 for exactly one cycle.
- ALU outputs (alu_op, alu_a, alu_b) hold their last value outside ISSUE.
- Throughput and latency:
  - One legal instruction every 3 cycles; one illegal instruction every cycle.
  - Accept edge → done high: 3 cycles legal, 1 cycle illegal.
- Hazards:
  - None exist: write-back completes before the next accept.
  - An instruction with rs1 or rs2 equal to the previous rd reads the updated value.
  - rd may equal rs1 or rs2.
- instr_valid is ignored outside IDLE; the source must hold instr stable until the handshake completes.
- rf is all-register with no RAM inference requirement. The debug port has no side effects.
- rst asserted during ISSUE or WB: no rf write, no flags_q update, done stays 0. After release, instr_ready = 1 in the first cycle.

Test Plan:
1. Reset, then instr {PASSB, rd=1, use_imm=1, imm=0x7F} → done 3 cycles after accept; rf[1]=0x7F; flags_q=4'b0000.
2. Load r2=0x01 via PASSB imm, then {ADD, rd=3, rs1=1, rs2=2} → rf[3]=0x80; flags_q=4'b1001 (N=1, V=1).
3. {SUB, rd=0, rs1=0 (0x00), use_imm=1, imm=0x01} → rf[0]=0xFF; flags_q=4'b1010. Then {ADD, rd=0, rs1=0, imm=0x01} → rf[0]=0x00; flags_q=4'b0110 (Z=1, C=1).
4. instr_valid held high with a back-to-back stream of 4 legal instructions → accepts at cycles t, t+3, t+6, t+9; rf matches a software model; no instruction lost or duplicated.
5. Illegal op 6'd63 with rd=2 → done and illegal pulse one cycle after accept; rf[2] and flags_q unchanged; the next instruction is accepted in the same cycle as the pulse.
6. ADD issued, rst pulsed during WB → done never rises; all rf=0; flags_q=0; instr_ready=1 in the first cycle after release.
